sm_clk_ctrl: RTL and testbench



---
 rtl/sm_clk_ctrl_pkg.sv | 22 ++
 rtl/sm_edge_detect.sv | 21 ++
 rtl/sm_clk_ctrl.sv | 136 +++++++++++++
 tb/tb_sm_clk_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_clk_ctrl_pkg.sv
// Shared encodings and widths for the clock run/halt/step controller.
package sm_clk_ctrl_pkg;

  localparam int DIV_W  = 4;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_SET_DIV = 2'd0,
    OP_RUN     = 2'd1,
    OP_HALT    = 2'd2,
    OP_STEP    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_STOPPING = 2'd3
  } state_e;

endpackage

// File: rtl/sm_edge_detect.sv
// Registered edge detector: one-cycle rise/fall strobes for a signal that is
// already synchronous to clk.
module sm_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Run/halt/single-step controller for the CPU clock divider. Stops are only
// taken on a divided-clock falling edge so the core never sees a runt pulse.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter bit               RESET_RUN = 1'b1,
  parameter logic [DIV_W-1:0] RESET_DIV = 4'd0
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic              clkDivIn,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdOp,
  input  logic [STEP_W-1:0] cmdArg,
  output logic [DIV_W-1:0]  devide,
  output logic              enable,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] stepLeft,
  output logic [CNT_W-1:0]  riseCnt,
  output logic              stepDone
);

  localparam state_e RESET_STATE = RESET_RUN ? ST_RUNNING : ST_HALTED;

  // Handshake: a command is consumed on a clkIn edge where cmdValid and
  // cmdReady are both high; cmdReady depends only on state and cmdOp.
  state_e             cur, nxt;
  op_e                op;
  logic               rise, fall, accept;
  logic               step_fin, step_fin_nxt;
  logic               done_nxt;
  logic [DIV_W-1:0]   div_nxt;
  logic [STEP_W-1:0]  left_nxt;

  sm_edge_detect u_edge (
    .clk  (clkIn),
    .rst  (rst),
    .sig  (clkDivIn),
    .rise (rise),
    .fall (fall)
  );

  assign op     = op_e'(cmdOp);
  assign state  = cur;
  assign accept = cmdValid & cmdReady;

  always_comb begin
    cmdReady = 1'b0;
    case (cur)
      ST_HALTED:   cmdReady = 1'b1;
      ST_RUNNING:  cmdReady = (op == OP_RUN) || (op == OP_HALT);
      ST_STEPPING: cmdReady = (op == OP_HALT);
      default:     cmdReady = 1'b0;
    endcase
  end

  always_comb begin
    nxt          = cur;
    div_nxt      = devide;
    left_nxt     = stepLeft;
    done_nxt     = 1'b0;
    step_fin_nxt = step_fin;
    case (cur)
      ST_HALTED: begin
        if (accept) begin
          case (op)
            OP_SET_DIV: div_nxt = cmdArg[DIV_W-1:0];
            OP_RUN:     nxt = ST_RUNNING;
            OP_STEP: begin
              if (cmdArg == '0) begin
                done_nxt = 1'b1;
              end else begin
                nxt      = ST_STEPPING;
                left_nxt = cmdArg;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RUNNING: begin
        if (accept && op == OP_HALT) begin
          nxt          = clkDivIn ? ST_STOPPING : ST_HALTED;
          step_fin_nxt = 1'b0;
        end
      end
      ST_STEPPING: begin
        // A HALT in the same cycle as a rise takes priority over the step.
        if (accept && op == OP_HALT) begin
          left_nxt     = '0;
          nxt          = clkDivIn ? ST_STOPPING : ST_HALTED;
          step_fin_nxt = 1'b0;
        end else if (rise) begin
          left_nxt = stepLeft - 1'b1;
          if (stepLeft == 8'd1) begin
            nxt          = ST_STOPPING;
            step_fin_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (fall) begin
          nxt          = ST_HALTED;
          done_nxt     = step_fin;
          step_fin_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      cur      <= RESET_STATE;
      enable   <= RESET_RUN;
      devide   <= RESET_DIV;
      stepLeft <= '0;
      stepDone <= 1'b0;
      step_fin <= 1'b0;
    end else begin
      cur      <= nxt;
      enable   <= (nxt != ST_HALTED);
      devide   <= div_nxt;
      stepLeft <= left_nxt;
      stepDone <= done_nxt;
      step_fin <= step_fin_nxt;
    end
  end

  // Rises while the divider is gated off are not real CPU periods.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst)                riseCnt <= '0;
    else if (rise & enable) riseCnt <= riseCnt + 1'b1;
  end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Bench for sm_clk_ctrl: scripted vectors, multi-cycle corner sequences with a
// divider model, and randomized commands against a reference model.
module tb_sm_clk_ctrl;
  import sm_clk_ctrl_pkg::*;

  logic        clkIn = 1'b0;
  logic        rst = 1'b1;
  logic        clkDivIn;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmdOp = 2'd0;
  logic [7:0]  cmdArg = 8'd0;
  logic [3:0]  devide;
  logic        enable;
  logic [1:0]  state;
  logic [7:0]  stepLeft;
  logic [15:0] riseCnt;
  logic        stepDone;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset / divider ----------------
  always #5 clkIn = ~clkIn;

  logic [31:0] div_cnt;
  logic        manual = 1'b1;
  logic        man_val = 1'b0;

  always @(posedge clkIn or posedge rst) begin
    if (rst)         div_cnt <= '0;
    else if (enable) div_cnt <= div_cnt + 32'd1;
  end

  assign clkDivIn = manual ? man_val : div_cnt[devide + 5'd1];

  sm_clk_ctrl dut (
    .clkIn    (clkIn),
    .rst      (rst),
    .clkDivIn (clkDivIn),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdOp    (cmdOp),
    .cmdArg   (cmdArg),
    .devide   (devide),
    .enable   (enable),
    .state    (state),
    .stepLeft (stepLeft),
    .riseCnt  (riseCnt),
    .stepDone (stepDone)
  );

  int done_cnt = 0;
  int obs_rise = 0;
  logic win = 1'b0;
  always @(negedge clkIn) if (stepDone) done_cnt++;
  always @(posedge clkDivIn) if (win) obs_rise++;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clkIn);
    rst = 1'b1;
    cmdValid = 1'b0;
    @(negedge clkIn);
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg, input string name);
    int i;
    @(negedge clkIn);
    cmdValid = 1'b1;
    cmdOp = op;
    cmdArg = arg;
    #1;
    i = 0;
    while (!cmdReady && i < 500) begin
      @(negedge clkIn);
      #1;
      i++;
    end
    check({name, "_accept"}, int'(cmdReady), 1);
    @(posedge clkIn);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget && int'(state) != s; i++) begin
      @(posedge clkIn);
      #1;
    end
    check(name, int'(state), s);
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 halted, 1 running, 2 stepping, 3 stopping.
  int          m_mode;
  logic [3:0]  m_div;
  logic [7:0]  m_left;
  logic [15:0] m_rcnt;
  logic        m_done, m_prev, m_by_step;

  task automatic model_reset();
    m_mode = 1; m_div = 4'd0; m_left = 8'd0; m_rcnt = 16'd0;
    m_done = 1'b0; m_prev = 1'b0; m_by_step = 1'b0;
  endtask

  function automatic int model_ready(input int op);
    if (m_mode == 0) return 1;
    if (m_mode == 1) return (op == 1 || op == 2) ? 1 : 0;
    if (m_mode == 2) return (op == 2) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_step(input bit v, input int op, input int arg, input bit din);
    bit got_rise, got_fall, take;
    got_rise = din && !m_prev;
    got_fall = !din && m_prev;
    take = v && (model_ready(op) == 1);
    if (got_rise && m_mode != 0) m_rcnt = m_rcnt + 16'd1;
    m_done = 1'b0;
    if (m_mode == 0) begin
      if (take && op == 0) m_div = arg[3:0];
      if (take && op == 1) m_mode = 1;
      if (take && op == 3) begin
        if (arg == 0) m_done = 1'b1;
        else begin m_mode = 2; m_left = arg[7:0]; end
      end
    end else if (m_mode == 1) begin
      if (take && op == 2) begin m_mode = din ? 3 : 0; m_by_step = 1'b0; end
    end else if (m_mode == 2) begin
      if (take && op == 2) begin
        m_left = 8'd0; m_mode = din ? 3 : 0; m_by_step = 1'b0;
      end else if (got_rise) begin
        m_left = m_left - 8'd1;
        if (m_left == 8'd0) begin m_mode = 3; m_by_step = 1'b1; end
      end
    end else if (got_fall) begin
      m_mode = 0; m_done = m_by_step; m_by_step = 1'b0;
    end
    m_prev = din;
  endtask

  task automatic check_model();
    check("rnd_state", int'(state), m_mode);
    check("rnd_enable", int'(enable), (m_mode != 0) ? 1 : 0);
    check("rnd_devide", int'(devide), int'(m_div));
    check("rnd_stepLeft", int'(stepLeft), int'(m_left));
    check("rnd_riseCnt", int'(riseCnt), int'(m_rcnt));
    check("rnd_stepDone", int'(stepDone), int'(m_done));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [7:0]  arg;
    logic        din;
    logic        rdy;
    int          st;
    logic        en;
    logic [3:0]  dv;
    logic [7:0]  left;
    logic        done;
    logic [15:0] rc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [1:0] op, input logic [7:0] arg, input logic din,
                     input logic rdy, input int st, input logic en, input logic [3:0] dv,
                     input logic [7:0] left, input logic done, input logic [15:0] rc);
    vec_t r;
    r = '{v, op, arg, din, rdy, st, en, dv, left, done, rc};
    vq.push_back(r);
  endtask

  initial begin
    int r0, o0, d0;
    bit v;
    int op, arg;

    // v  op          arg    din rdy st en div left done rcnt
    add(0, OP_RUN,     8'd0,  1,  1,  1, 1, 0, 0,  0,   1);
    add(1, OP_SET_DIV, 8'd3,  1,  0,  1, 1, 0, 0,  0,   1);
    add(1, OP_HALT,    8'd0,  1,  1,  3, 1, 0, 0,  0,   1);
    add(1, OP_RUN,     8'd0,  1,  0,  3, 1, 0, 0,  0,   1);
    add(0, OP_RUN,     8'd0,  0,  0,  0, 0, 0, 0,  0,   1);
    add(1, OP_SET_DIV, 8'h03, 0,  1,  0, 0, 3, 0,  0,   1);
    add(1, OP_STEP,    8'd0,  0,  1,  0, 0, 3, 0,  1,   1);
    add(0, OP_STEP,    8'd0,  0,  1,  0, 0, 3, 0,  0,   1);
    add(1, OP_STEP,    8'd2,  0,  1,  2, 1, 3, 2,  0,   1);
    add(1, OP_SET_DIV, 8'd5,  0,  0,  2, 1, 3, 2,  0,   1);
    add(0, OP_SET_DIV, 8'd0,  1,  0,  2, 1, 3, 1,  0,   2);
    add(0, OP_SET_DIV, 8'd0,  0,  0,  2, 1, 3, 1,  0,   2);
    add(0, OP_SET_DIV, 8'd0,  1,  0,  3, 1, 3, 0,  0,   3);
    add(0, OP_SET_DIV, 8'd0,  0,  0,  0, 0, 3, 0,  1,   3);
    add(0, OP_SET_DIV, 8'd0,  0,  1,  0, 0, 3, 0,  0,   3);
    add(1, OP_RUN,     8'd0,  1,  1,  1, 1, 3, 0,  0,   3);
    add(1, OP_HALT,    8'd0,  0,  1,  0, 0, 3, 0,  0,   3);
    add(1, OP_STEP,    8'd10, 0,  1,  2, 1, 3, 10, 0,   3);
    add(0, OP_RUN,     8'd0,  1,  0,  2, 1, 3, 9,  0,   4);
    add(0, OP_RUN,     8'd0,  0,  0,  2, 1, 3, 9,  0,   4);
    add(1, OP_HALT,    8'd0,  1,  1,  3, 1, 3, 0,  0,   5);
    add(0, OP_HALT,    8'd0,  0,  0,  0, 0, 3, 0,  0,   5);

    // Reset values, sampled while reset is held.
    #12;
    check("rst_state", int'(state), 1);
    check("rst_enable", int'(enable), 1);
    check("rst_devide", int'(devide), 0);
    check("rst_stepLeft", int'(stepLeft), 0);
    check("rst_riseCnt", int'(riseCnt), 0);
    check("rst_stepDone", int'(stepDone), 0);
    @(negedge clkIn);
    rst = 1'b0;

    // Scripted vectors with clkDivIn driven directly.
    foreach (vq[i]) begin
      @(negedge clkIn);
      cmdValid = vq[i].v;
      cmdOp = vq[i].op;
      cmdArg = vq[i].arg;
      man_val = vq[i].din;
      #1;
      check($sformatf("vec%0d_ready", i), int'(cmdReady), int'(vq[i].rdy));
      @(posedge clkIn);
      #1;
      check($sformatf("vec%0d_state", i), int'(state), vq[i].st);
      check($sformatf("vec%0d_enable", i), int'(enable), int'(vq[i].en));
      check($sformatf("vec%0d_devide", i), int'(devide), int'(vq[i].dv));
      check($sformatf("vec%0d_stepLeft", i), int'(stepLeft), int'(vq[i].left));
      check($sformatf("vec%0d_stepDone", i), int'(stepDone), int'(vq[i].done));
      check($sformatf("vec%0d_riseCnt", i), int'(riseCnt), int'(vq[i].rc));
    end
    cmdValid = 1'b0;

    // Free-running divider after reset: divide 0 gives a 4-cycle period.
    manual = 1'b0;
    do_reset();
    repeat (40) @(posedge clkIn);
    #1;
    check("run_riseCnt", int'(riseCnt), 10);

    // SET_DIV held off while running, accepted once halted.
    @(negedge clkIn);
    cmdValid = 1'b1; cmdOp = OP_SET_DIV; cmdArg = 8'h03;
    #1;
    check("setdiv_run_ready", int'(cmdReady), 0);
    @(posedge clkIn);
    #1;
    check("setdiv_run_devide", int'(devide), 0);
    cmdValid = 1'b0;
    send_cmd(OP_HALT, 8'd0, "halt1");
    wait_state(0, 100, "halt1_state");
    repeat (3) @(posedge clkIn);
    #1;
    check("halt1_enable", int'(enable), 0);
    send_cmd(OP_SET_DIV, 8'h03, "setdiv");
    check("setdiv_devide", int'(devide), 3);

    // STEP 5 with divide 3.
    r0 = int'(riseCnt); o0 = obs_rise; d0 = done_cnt;
    win = 1'b1;
    send_cmd(OP_STEP, 8'd5, "step5");
    wait_state(0, 2000, "step5_state");
    repeat (4) @(posedge clkIn);
    #1;
    win = 1'b0;
    check("step5_riseCnt_delta", int'(riseCnt) - r0, 5);
    check("step5_pulses", obs_rise - o0, 5);
    check("step5_done_cnt", done_cnt - d0, 1);
    check("step5_enable", int'(enable), 0);
    check("step5_clkDiv_low", int'(clkDivIn), 0);

    // HALT during STEP 10 after three rises: no stepDone.
    d0 = done_cnt;
    send_cmd(OP_STEP, 8'd10, "step10");
    for (int i = 0; i < 1000 && stepLeft > 8'd7; i++) begin
      @(posedge clkIn);
      #1;
    end
    check("step10_left7", int'(stepLeft), 7);
    send_cmd(OP_HALT, 8'd0, "step10_halt");
    check("step10_halt_left", int'(stepLeft), 0);
    wait_state(0, 100, "step10_halt_state");
    repeat (4) @(posedge clkIn);
    #1;
    check("step10_no_done", done_cnt - d0, 0);
    check("step10_enable", int'(enable), 0);

    // Reset asserted mid-STEP.
    send_cmd(OP_STEP, 8'd10, "step10b");
    repeat (20) @(posedge clkIn);
    #2;
    check("midstep_state_before", int'(state), 2);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("midstep_rst_state", int'(state), 1);
    check("midstep_rst_enable", int'(enable), 1);
    check("midstep_rst_devide", int'(devide), 0);
    check("midstep_rst_stepLeft", int'(stepLeft), 0);
    check("midstep_rst_riseCnt", int'(riseCnt), 0);
    check("midstep_rst_stepDone", int'(stepDone), 0);
    @(negedge clkIn);
    rst = 1'b0;
    @(negedge clkIn);
    check("midstep_no_done", done_cnt - d0, 0);

    // Randomized commands against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clkIn);
      v = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 3);
      arg = (op == 0) ? $urandom_range(0, 2) : $urandom_range(0, 4);
      cmdValid = v; cmdOp = op[1:0]; cmdArg = arg[7:0];
      #1;
      check("rnd_ready", int'(cmdReady), model_ready(op));
      model_step(v, op, arg, clkDivIn);
      @(posedge clkIn);
      #1;
      check_model();
    end
    cmdValid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
